// File: rtl/sales_pkg.sv
// ============================================================================
// sales_pkg: shared constants, FSM encoding and saturating add for sales_avg_multi
// Rev 1.0
// ============================================================================
`default_nettype none

package sales_pkg;

  localparam int DEF_W     = 32;
  localparam int DEF_ACC_W = 64;
  localparam int DEF_CH    = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DIV   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Widest accumulator the saturating helper supports; callers truncate.
  localparam int SAT_MAX_W = 128;

  function automatic logic [SAT_MAX_W-1:0] sat_add(
    input logic [SAT_MAX_W-1:0] a,
    input logic [SAT_MAX_W-1:0] b,
    input int                   w
  );
    logic [SAT_MAX_W:0] sum;
    logic [SAT_MAX_W:0] lim;
    lim = ({{SAT_MAX_W{1'b0}}, 1'b1} << w) - 1'b1;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > lim) ? lim[SAT_MAX_W-1:0] : sum[SAT_MAX_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sales_avg_multi_if.sv
// ============================================================================
// sales_avg_multi_if: transaction-in / average-out handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface sales_avg_multi_if
  import sales_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int CH = DEF_CH
);
  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

  logic            in_valid;
  logic            in_ready;
  logic [CH_W-1:0] in_ch;
  logic            in_clr;
  logic [W-1:0]    in_price;
  logic [W-1:0]    in_num;
  logic            out_valid;
  logic            out_ready;
  logic [CH_W-1:0] out_ch;
  logic [W-1:0]    out_avg;

  modport master (
    output in_valid, in_ch, in_clr, in_price, in_num, out_ready,
    input  in_ready, out_valid, out_ch, out_avg
  );

  modport slave (
    input  in_valid, in_ch, in_clr, in_price, in_num, out_ready,
    output in_ready, out_valid, out_ch, out_avg
  );

endinterface

`default_nettype wire

// File: rtl/sales_serial_div.sv
// ============================================================================
// sales_serial_div: restoring divider, one quotient bit per cycle, ACC_W cycles
// Rev 1.0
// ============================================================================
`default_nettype none

module sales_serial_div
  import sales_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ACC_W-1:0] dividend,
  input  logic [ACC_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] quotient,
  output logic [ACC_W-1:0] remainder
);
  localparam int CNT_W = $clog2(ACC_W + 1);

  logic [ACC_W-1:0] rem_q, quo_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;

  logic [ACC_W-1:0] src_rem, src_quo, src_dvs;
  logic [ACC_W:0]   trial, diff;
  logic             ge;
  logic [ACC_W-1:0] nxt_rem, nxt_quo;

  // The start cycle already performs the first step on the incoming operands,
  // so the full ACC_W steps finish ACC_W edges after the start edge.
  always_comb begin
    src_rem = start ? '0 : rem_q;
    src_quo = start ? dividend : quo_q;
    src_dvs = start ? divisor : dvs_q;
    trial   = {src_rem, src_quo[ACC_W-1]};
    diff    = trial - {1'b0, src_dvs};
    ge      = (trial >= {1'b0, src_dvs});
    nxt_rem = ge ? diff[ACC_W-1:0] : trial[ACC_W-1:0];
    nxt_quo = {src_quo[ACC_W-2:0], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q <= nxt_rem;
        quo_q <= nxt_quo;
        dvs_q <= divisor;
        cnt_q <= CNT_W'(ACC_W - 1);
        busy  <= 1'b1;
      end else if (busy) begin
        rem_q <= nxt_rem;
        quo_q <= nxt_quo;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

`default_nettype wire

// File: rtl/sales_avg_multi.sv
// ============================================================================
// sales_avg_multi: multi-channel running weighted-average price engine
// Optional macro SALES_AVG_SAT_EN: saturating accumulators. Rev 1.0
// ============================================================================
`default_nettype none

module sales_avg_multi
  import sales_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CH    = DEF_CH
) (
  input  logic               clk,
  input  logic               rst,
  sales_avg_multi_if.slave   bus
);
  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

  logic [1:0]       state, state_nxt;

  logic [CH_W-1:0]  lat_ch;
  logic             lat_clr;
  logic [W-1:0]     lat_price, lat_num;

  logic [ACC_W-1:0] rev_a [CH];
  logic [ACC_W-1:0] qty_a [CH];

  logic             ch_ok;
  logic [2*W-1:0]   prod;
  logic [ACC_W-1:0] prod_ext, num_ext;
  logic [ACC_W-1:0] base_rev, base_qty;
  logic [ACC_W-1:0] new_rev, new_qty;

  logic             div_start, div_busy, div_done;
  logic [ACC_W-1:0] div_quo, div_rem;
  logic             unused_div;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (bus.in_valid) state_nxt = ST_ACCUM;
      ST_ACCUM: state_nxt = div_start ? ST_DIV : ST_DONE;
      ST_DIV:   if (div_done) state_nxt = ST_DONE;
      ST_DONE:  if (bus.out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.in_ready  = (state == ST_IDLE);
    bus.out_valid = (state == ST_DONE);
    div_start     = (state == ST_ACCUM) && ch_ok && (new_qty != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_ch    <= '0;
      lat_clr   <= 1'b0;
      lat_price <= '0;
      lat_num   <= '0;
    end else if (state == ST_IDLE && bus.in_valid) begin
      lat_ch    <= bus.in_ch;
      lat_clr   <= bus.in_clr;
      lat_price <= bus.in_price;
      lat_num   <= bus.in_num;
    end
  end

  // Out-of-range channels (non-power-of-2 CH) read as empty and are never written.
  always_comb begin
    ch_ok    = (int'(lat_ch) < CH);
    prod     = {{W{1'b0}}, lat_price} * {{W{1'b0}}, lat_num};
    prod_ext = ACC_W'(prod);
    num_ext  = ACC_W'(lat_num);
    base_rev = (lat_clr || !ch_ok) ? '0 : rev_a[lat_ch];
    base_qty = (lat_clr || !ch_ok) ? '0 : qty_a[lat_ch];
`ifdef SALES_AVG_SAT_EN
    new_rev  = ACC_W'(sat_add(SAT_MAX_W'(base_rev), SAT_MAX_W'(prod_ext), ACC_W));
    new_qty  = ACC_W'(sat_add(SAT_MAX_W'(base_qty), SAT_MAX_W'(num_ext), ACC_W));
`else
    new_rev  = base_rev + prod_ext;
    new_qty  = base_qty + num_ext;
`endif
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rev_a[i] <= '0;
        qty_a[i] <= '0;
      end else if (state == ST_ACCUM && ch_ok && lat_ch == CH_W'(i)) begin
        rev_a[i] <= new_rev;
        qty_a[i] <= new_qty;
      end
    end
  end

  sales_serial_div #(.ACC_W(ACC_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (new_rev),
    .divisor   (new_qty),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Upper quotient bits are zero whenever the accumulators are exact.
  assign unused_div = ^{div_busy, div_rem, div_quo[ACC_W-1:W]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_ch  <= '0;
      bus.out_avg <= '0;
    end else if (state == ST_ACCUM) begin
      bus.out_ch <= lat_ch;
      if (!div_start) bus.out_avg <= '0;
    end else if (state == ST_DIV && div_done) begin
      bus.out_avg <= div_quo[W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: doc/sales_avg_multi.md
Name: sales_avg_multi

Overview:
Multi-channel running weighted-average price engine, the parametrised successor of the single-channel sales averager.
- Keeps per-channel accumulators of total quantity and total revenue (sum of num*price).
- After each accepted transaction, computes the channel's average price (revenue / quantity) with a multi-cycle serial divider.
- Sits between the transaction source and the reporting logic; valid/ready handshake on both sides.

Parameters:
W, 32, width of price, num and avg
ACC_W, 64, width of per-channel revenue and quantity accumulators; must be >= 2*W
CH, 4, number of independent channels
CH_W, $clog2(CH) (min 1), channel index width, derived localparam

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; asynchronous, active-high
in_valid  input  1  transaction present
in_ready  output  1  engine can accept a transaction
in_ch  input  CH_W  target channel
in_clr  input  1  restart channel: discard old totals before applying this transaction
in_price  input  W  unit price
in_num  input  W  quantity
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
out_ch  output  CH_W  channel of result
out_avg  output  W  floor(revenue/quantity) of channel after update; 0 if quantity is 0

Behaviour:
- Reset (async, any state): all accumulators 0, FSM to IDLE, in_ready=1, out_valid=0, out_ch=0, out_avg=0.
- FSM states: IDLE, ACCUM, DIV, DONE.
  - IDLE: in_ready=1. On in_valid, latch ch/clr/price/num, go to ACCUM.
  - ACCUM (1 cycle), per channel: rev <= (clr?0:rev) + num*price; qty <= (clr?0:qty) + num.
    - New qty==0: out_avg<=0, go to DONE.
    - Otherwise load divider (dividend=new rev, divisor=new qty), go to DIV.
  - DIV: restoring divider, one quotient bit per cycle, exactly ACC_W cycles, then out_avg <= quotient[W-1:0] and go to DONE.
    - Truncation is lossless: a weighted average never exceeds the maximum price when accumulators are exact.
  - DONE: out_valid=1, out_ch/out_avg stable. When out_ready=1, go to IDLE the next cycle.
- in_ready=0 in ACCUM/DIV/DONE; in_valid there is ignored, so the source must hold it.
- Latency, counted from the accepting edge E0:
  - Nonzero qty: out_valid high after edge E0+1+ACC_W.
  - Zero qty: out_valid high after E0+1.
- Arithmetic:
  - num*price is a full 2W-bit product, zero-extended to ACC_W.
  - Without the optional feature, additions wrap modulo 2^ACC_W.
- Channels are independent. A transaction on one channel never alters another channel's accumulators.
- in_ch >= CH (non-power-of-2 CH): transaction accepted, no accumulator changes, result out_avg=0 with out_ch=in_ch.
- Back-to-back: next transaction can be accepted one cycle after the out handshake. No overlap.

Optional Feature:
Macro SALES_AVG_SAT_EN.
- Defined: revenue and quantity additions saturate at 2^ACC_W-1. A saturated accumulator stays saturated until a clr transaction or reset.
- Undefined: wrap-around as above, with no saturation logic.

Decomposition:
- Package sales_pkg holds:
  - FSM state encoding constants (IDLE/ACCUM/DIV/DONE).
  - Default W/ACC_W/CH.
  - Function for saturating add, used when SALES_AVG_SAT_EN is defined.
- One sub-module, sales_serial_div: ACC_W-bit restoring divider.
  - Signals: start, busy, done, quotient, remainder.
  - Fixed ACC_W-cycle latency; async reset.

Test Plan:
- ch0 price=10 num=3 -> out_avg=10, out_ch=0. Then ch0 price=20 num=1 -> out_avg=12 (rev 50, qty 4), out_valid after edge E0+65.
- Fresh ch2 price=99 num=0 -> out_avg=0, out_valid after E0+1, no divider run. ch0 total unaffected: next ch0 price=12 num=0 -> 12.
- ch0 in_clr=1 price=7 num=2 -> out_avg=7. Then ch1 price=5 num=1 -> 5, proving channel isolation.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid/out_avg/out_ch stable, in_ready=0, in_valid pulses ignored. out_ready=1 -> in_ready=1 next cycle.
- Assert rst 10 cycles into DIV -> out_valid=0 and in_ready=1 immediately (asynchronous). All accumulators 0: next ch0 price=4 num=1 -> 4.
- Twice ch3 price=0xFFFFFFFF num=0xFFFFFFFF:
  - With SALES_AVG_SAT_EN: second result 0x80000000.
  - Without: wrapped revenue gives 0x7FFFFFFE.
